// File: rtl/round_robin_arbiter_4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// State encoding, requester count and index width live here.
package round_robin_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage : round_robin_arbiter_4_pkg

// File: rtl/round_robin_arbiter_4_if.sv
// Requester-side bus of the 4-way round-robin arbiter.
// The master modport is the arbiter and the slave modport is the requester pool.
interface round_robin_arbiter_4_if;
  import round_robin_arbiter_4_pkg::*;

  // Level handshake: req[i] stays high for as long as requester i wants or
  // holds the resource. gnt[i] high means i owns it. Dropping req[i] while
  // granted releases the resource. gnt_id is meaningful only while busy=1.
  // timeout pulses for one cycle when a grant is forcibly revoked.
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             busy;
  logic             timeout;
  arb_state_e       dbg_state;

  modport master (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout,
    output dbg_state
  );

  modport slave (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout,
    input  dbg_state
  );

endinterface : round_robin_arbiter_4_if

// File: rtl/round_robin_arbiter_4_decoder_2x4.sv
// 2-to-4 one-hot decoder with enable. It turns the latched grant index into gnt.
module decoder_2x4
  import round_robin_arbiter_4_pkg::*;
(
  input  logic [IDX_W-1:0] i_a,
  input  logic             i_e,
  output logic [N_REQ-1:0] o_y
);

  always_comb begin
    o_y = '0;
    if (i_e) begin
      o_y[i_a] = 1'b1;
    end
  end

endmodule : decoder_2x4

// File: rtl/round_robin_arbiter_4.sv
// 4-way round-robin arbiter. It uses a two-state IDLE/GRANT FSM and always leaves one dead cycle between grants.
// Defining ARB_TIMEOUT_EN builds a hold counter that revokes any grant held for HOLD_MAX cycles.
module round_robin_arbiter_4
  import round_robin_arbiter_4_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  round_robin_arbiter_4_if.master bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold_max
    $error("HOLD_MAX must be within 2..256");
  end

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_sel, w_sel_nxt;
  logic             w_found;
  logic [IDX_W-1:0] w_win;
  logic             w_in_grant;
  logic             w_sel_req;
  logic             w_hold_expire;

  assign w_in_grant = (r_state == ST_GRANT);
  assign w_sel_req  = bus.req[r_sel];

  // The first requester at or after ptr wins. The index sum wraps in 2 bits.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && bus.req[r_ptr + IDX_W'(i)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + IDX_W'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_timeout;

  // The counter is held at zero in IDLE, so every GRANT starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_hold_cnt <= w_in_grant ? r_hold_cnt + 1'b1 : '0;
      r_timeout  <= w_hold_expire;
    end
  end

  // A release on the expiry edge takes precedence, so it produces no pulse.
  assign w_hold_expire = w_in_grant && w_sel_req && (r_hold_cnt == CNT_LAST);
  assign bus.timeout   = r_timeout;
`else
  assign w_hold_expire = 1'b0;
  assign bus.timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_win;
        end
      end
      ST_GRANT: begin
        if (!w_sel_req || w_hold_expire) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = r_sel + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  decoder_2x4 u_gnt_dec (
    .i_a (r_sel),
    .i_e (w_in_grant),
    .o_y (bus.gnt)
  );

  assign bus.busy      = w_in_grant;
  assign bus.gnt_id    = w_in_grant ? r_sel : '0;
  assign bus.dbg_state = r_state;

endmodule : round_robin_arbiter_4

// File: tb/tb_round_robin_arbiter_4.sv
// Self-checking bench for round_robin_arbiter_4. The ARB_TIMEOUT_EN build runs the hold-timeout scenarios.
module tb_round_robin_arbiter_4;
  import round_robin_arbiter_4_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  round_robin_arbiter_4_if bus ();

  round_robin_arbiter_4 #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_g;

  // Returns 1 ns after the rising edge. Samples are taken and inputs are driven at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req = 4'b1111;
    rst_n   = 1'b0;
    repeat (3) tick();
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    n_tests++; if (bus.gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id: got %0d want 0", bus.gnt_id); end
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    tick();
    exp_g = exp_q.pop_front();
    n_tests++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL reset_first_gnt: got %b want %b", bus.gnt, exp_g); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy: got %b want 1", bus.busy); end
    n_tests++; if (bus.gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_first_id: got %0d want 0", bus.gnt_id); end
  endtask

  task automatic test_rotation();
    rst_n   = 1'b0;
    tick();
    bus.req = 4'b1111;
    rst_n   = 1'b1;
    exp_q.push_back(4'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = exp_q.pop_front();
      n_tests++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL rot_gnt k=%0d: got %b want %b", k, bus.gnt, exp_g); end
      n_tests++; if (bus.gnt_id !== 2'(k % 4)) begin n_fail++; $display("FAIL rot_id k=%0d: got %0d want %0d", k, bus.gnt_id, k % 4); end
      repeat (2) tick();
      n_tests++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL rot_hold k=%0d: got %b want %b", k, bus.gnt, exp_g); end
      bus.req[k % 4] = 1'b0;
      tick();
      n_tests++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rot_dead k=%0d: got gnt=%b busy=%b want 0000/0", k, bus.gnt, bus.busy); end
      if (k < 4) begin
        bus.req[k % 4] = 1'b1;
        exp_q.push_back(4'b0001 << ((k + 1) % 4));
        tick();
      end
    end
    bus.req = 4'b0000;
    tick();
  endtask

  // The rotation ends with ptr=1. Granting 2 and releasing it moves ptr to 3.
  task automatic test_wrap();
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    exp_g = exp_q.pop_front();
    n_tests++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL wrap_pre: got %b want %b", bus.gnt, exp_g); end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0101;
    exp_q.push_back(4'b0001);
    tick();
    exp_g = exp_q.pop_front();
    n_tests++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL wrap_gnt: got %b want %b", bus.gnt, exp_g); end
    n_tests++; if (bus.gnt_id !== 2'd0) begin n_fail++; $display("FAIL wrap_id: got %0d want 0", bus.gnt_id); end
    repeat (2) begin
      tick();
      n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL no_preempt: got %b want 0001", bus.gnt); end
    end
    bus.req = 4'b0100;
    tick();
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL wrap_dead: got %b want 0000", bus.gnt); end
    exp_q.push_back(4'b0100);
    tick();
    exp_g = exp_q.pop_front();
    n_tests++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL wrap_next: got %b want %b", bus.gnt, exp_g); end
  endtask

  task automatic test_mid_grant_reset();
    bus.req = 4'b0110;
    tick();
    n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_pre: got %b want 0100", bus.gnt); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_async_gnt: got %b want 0000", bus.gnt); end
    n_tests++; if (bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL mid_async_flags: got busy=%b timeout=%b want 0/0", bus.busy, bus.timeout); end
    #2 rst_n = 1'b1;
    exp_q.push_back(4'b0010);
    tick();
    exp_g = exp_q.pop_front();
    n_tests++; if (bus.gnt !== exp_g) begin n_fail++; $display("FAIL mid_regrant: got %b want %b", bus.gnt, exp_g); end
    n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL mid_timeout: got %b want 0", bus.timeout); end
    bus.req = 4'b0000;
    repeat (2) tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req = 4'b0010;
    tick();
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_hold c=%0d: got gnt=%b timeout=%b want 0010/0", c, bus.gnt, bus.timeout); end
      tick();
    end
    n_tests++; if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got gnt=%b timeout=%b want 0000/1", bus.gnt, bus.timeout); end
    exp_q.push_back(4'b0010);
    tick();
    exp_g = exp_q.pop_front();
    n_tests++; if (bus.gnt !== exp_g || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_regrant: got gnt=%b timeout=%b want %b/0", bus.gnt, bus.timeout, exp_g); end
    repeat (3) tick();
    n_tests++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL same_edge_hold: got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    n_tests++; if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL same_edge_rel: got gnt=%b timeout=%b want 0000/0", bus.gnt, bus.timeout); end
    tick();
    n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL same_edge_after: got %b want 0", bus.timeout); end
  endtask
`else
  task automatic test_no_timeout();
    bus.req = 4'b0010;
    tick();
    for (int c = 0; c < 100; c++) begin
      n_tests++; if (bus.gnt !== 4'b0010 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL unbounded c=%0d: got gnt=%b timeout=%b want 0010/0", c, bus.gnt, bus.timeout); end
      tick();
    end
    bus.req = 4'b0000;
    repeat (2) tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_rotation();
    test_wrap();
    test_mid_grant_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_round_robin_arbiter_4

// File: doc/round_robin_arbiter_4.md
ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 Parameter HOLD_MAX, default 16, maximum consecutive cycles one grant is held (timeout build only); legal range 2..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request from requesters 0..3, level; held high while the requester wants or is using the shared resource.
REQ-005 gnt  output  4  one-hot grant; at most one bit high in any cycle.
REQ-006 gnt_id  output  2  binary index of the granted requester; valid only while busy=1.
REQ-007 busy  output  1  high while any grant is active.
REQ-008 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-009 FSM has two states: IDLE and GRANT; all outputs are registered or decoded from registered state only.
REQ-010 IDLE: if req != 0, select the first requester with req high, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); latch its index into sel and enter GRANT.
REQ-011 Grant latency: gnt asserts exactly one cycle after the edge where req is sampled in IDLE.
REQ-012 GRANT: gnt = one-hot decode of sel, gnt_id = sel, busy = 1; gnt held while req[sel] = 1.
REQ-013 GRANT: when req[sel] = 0 on a sampling edge, return to IDLE and set ptr = sel+1 (mod 4); gnt is 0 in the following cycle (one dead cycle between grants, always).
REQ-014 Requests from non-granted requesters during GRANT are ignored (no preemption); they compete at the next IDLE.
REQ-015 Simultaneous requests: rotating priority only; a requester continuously requesting waits at most 3 other grants.
REQ-016 Requester dropping and re-raising req in the same dead cycle is treated as a new request, with lowest priority against the rotated ptr.
REQ-017 In IDLE, gnt = 0, busy = 0, gnt_id = 0.
REQ-018 ptr arithmetic is 2-bit unsigned, wraps 3 -> 0.

Reset
REQ-019 rst_n low forces, asynchronously: state = IDLE, ptr = 0, sel = 0, hold counter = 0, gnt = 0, gnt_id = 0, busy = 0, timeout = 0.
REQ-020 Reset asserted mid-GRANT drops gnt immediately without timeout pulse; after release, arbitration restarts from ptr = 0.
REQ-021 First arbitration after rst_n rises happens on the first rising edge with rst_n high.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN compiles in the hold-timeout feature.
REQ-023 With ARB_TIMEOUT_EN: hold counter clears on entering GRANT, increments each GRANT cycle; when it reaches HOLD_MAX-1 with req[sel] still high, return to IDLE, ptr = sel+1, timeout = 1 for exactly the next cycle, gnt = 0 that cycle.
REQ-024 With ARB_TIMEOUT_EN: if req[sel] falls on the same edge the counter reaches HOLD_MAX-1, it is a normal release, no timeout pulse.
REQ-025 Without ARB_TIMEOUT_EN: no counter is built, grants are unbounded, timeout is tied to 0; ports identical in both builds.

Structure
REQ-026 Shared package holds state encoding (IDLE=0, GRANT=1), requester count constant (4) and index width constant (2).
REQ-027 One sub-module: decoder_2x4 (2-bit input, enable, 4-bit one-hot output) instantiated with A = sel, E = GRANT-state flag, output driving gnt.
REQ-028 Round-robin search is combinational logic in the top module.

Verification
REQ-029 Reset: rst_n low while req = 4'b1111 -> gnt = 0, busy = 0, timeout = 0; rst_n high -> gnt = 4'b0001 one cycle after first sample.
REQ-030 Rotation: req = 4'b1111 held, each holder drops req 3 cycles after grant then re-raises -> grant order 0,1,2,3,0 with one dead cycle between grants.
REQ-031 Wrap: ptr = 3 after granting 2, req = 4'b0101 -> gnt = 4'b0001 (index 0 before 2).
REQ-032 Mid-grant reset: gnt = 4'b0100 held, rst_n pulsed low -> gnt = 0 asynchronously, no timeout pulse, next grant to lowest requester from ptr = 0.
REQ-033 Timeout (ARB_TIMEOUT_EN, HOLD_MAX = 4): req = 4'b0010 held -> gnt = 4'b0010 for 4 cycles, then timeout = 1 and gnt = 0 for one cycle, then re-granted to 1.
REQ-034 Same-edge release (ARB_TIMEOUT_EN, HOLD_MAX = 4): req[1] drops on the 4th grant cycle -> no timeout pulse; without macro, req held 100 cycles -> gnt stays 4'b0010, timeout = 0.
